// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX stage and the M-extension unit.
// Handshake: stall_req_o=1 means not ready (hold ID/EX); a result transfers when result_valid_o=1 and ex_advance_i=1 in the same cycle.
interface ex_muldiv_if;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [63:0] rs1_data_i;
  logic [63:0] rs2_data_i;
  logic        flush_i;
  logic        ex_advance_i;
  logic        stall_req_o;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic [1:0]  dbg_state_o;

  modport master (
    output opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, flush_i, ex_advance_i,
    input  stall_req_o, result_o, result_valid_o, dbg_state_o
  );

  modport slave (
    input  opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, flush_i, ex_advance_i,
    output stall_req_o, result_o, result_valid_o, dbg_state_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV64 M-extension unit: shift-add multiply, radix-2 restoring divide on magnitudes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module ex_muldiv (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_RW = 7'b0111011;
  localparam logic [6:0] F7_M  = 7'b0000001;

  state_t       r_state, w_state_next;
  logic [5:0]   r_cnt;
  logic         r_div, r_w, r_rem, r_hi, r_special, r_neg, r_neg_r;
  logic [63:0]  r_spec_res, r_x, r_y, r_rrem, r_result;
  logic [127:0] r_mcand, r_acc;

  logic         w_is_m, w_is_w, w_is_div, w_is_rem, w_sa, w_sb;
  logic [63:0]  w_rs1_sx, w_rs2_sx, w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_div;
  logic         w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;
  logic [63:0]  w_spec_res;
  logic [5:0]   w_cnt_init;
  logic         w_start, w_stall, w_valid;

  logic [127:0] w_acc_next, w_prod;
  logic [64:0]  w_shift;
  logic         w_ge;
  logic [63:0]  w_diff, w_rem_next, w_q_next, w_q_fin, w_r_fin;
  logic [63:0]  w_div_sel, w_mul_sel, w_final;

  // Decode and operand preparation for the instruction currently in ID/EX.
  always_comb begin
    w_is_w   = (bus.opcode_i == OP_RW);
    w_is_m   = (bus.funct7_i == F7_M) &&
               ((bus.opcode_i == OP_R) ||
                (w_is_w && ((bus.funct3_i == 3'b000) || bus.funct3_i[2])));
    w_is_div = bus.funct3_i[2];
    w_is_rem = bus.funct3_i[1];
    w_sa     = w_is_div ? ~bus.funct3_i[0]
                        : ((bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010));
    w_sb     = w_is_div ? ~bus.funct3_i[0] : (bus.funct3_i == 3'b001);
    w_rs1_sx = {{32{bus.rs1_data_i[31]}}, bus.rs1_data_i[31:0]};
    w_rs2_sx = {{32{bus.rs2_data_i[31]}}, bus.rs2_data_i[31:0]};
    w_a_ext  = bus.rs1_data_i;
    w_b_ext  = bus.rs2_data_i;
    if (w_is_w) begin
      w_a_ext = w_sa ? w_rs1_sx : {32'd0, bus.rs1_data_i[31:0]};
      w_b_ext = w_sb ? w_rs2_sx : {32'd0, bus.rs2_data_i[31:0]};
    end
    w_a_neg    = w_sa & w_a_ext[63];
    w_b_neg    = w_sb & w_b_ext[63];
    w_a_mag    = w_a_neg ? (64'd0 - w_a_ext) : w_a_ext;
    w_b_mag    = w_b_neg ? (64'd0 - w_b_ext) : w_b_ext;
    w_a_div    = w_is_w ? w_rs1_sx : bus.rs1_data_i;
    w_div_zero = w_is_div && (w_b_ext == 64'd0);
    w_ovf      = w_is_div && w_sa &&
                 (w_a_ext == (w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) &&
                 (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero)
      w_spec_res = w_is_rem ? w_a_div : 64'hFFFF_FFFF_FFFF_FFFF;
    else
      w_spec_res = w_is_rem ? 64'd0 : w_a_div;
    // Counter holds N-1 so the last iteration runs in the cycle it reads zero.
`ifdef MULDIV_FAST_MUL_EN
    w_cnt_init = (w_special || !w_is_div) ? 6'd0 : (w_is_w ? 6'd31 : 6'd63);
`else
    w_cnt_init = w_special ? 6'd0 : (w_is_w ? 6'd31 : 6'd63);
`endif
  end

  // One iteration of multiply and divide per BUSY cycle, plus sign fix-up.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    w_acc_next = r_acc + (r_mcand * {64'd0, r_x});
`else
    w_acc_next = r_acc + (r_x[0] ? r_mcand : 128'd0);
`endif
    w_prod     = r_neg ? (128'd0 - w_acc_next) : w_acc_next;
    w_mul_sel  = r_hi ? w_prod[127:64] : w_prod[63:0];
    if (r_w)
      w_mul_sel = {{32{w_prod[31]}}, w_prod[31:0]};
    w_shift    = {r_rrem, r_x[63]};
    w_ge       = (w_shift >= {1'b0, r_y});
    w_diff     = w_shift[63:0] - r_y;
    w_rem_next = w_ge ? w_diff : w_shift[63:0];
    w_q_next   = {r_x[62:0], w_ge};
    w_q_fin    = r_neg ? (64'd0 - w_q_next) : w_q_next;
    w_r_fin    = r_neg_r ? (64'd0 - w_rem_next) : w_rem_next;
    w_div_sel  = r_rem ? w_r_fin : w_q_fin;
    if (r_w)
      w_div_sel = {{32{w_div_sel[31]}}, w_div_sel[31:0]};
    w_final    = r_special ? r_spec_res : (r_div ? w_div_sel : w_mul_sel);
  end

  assign w_start = (r_state == S_IDLE) && w_is_m && !bus.flush_i;

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_BUSY;
        w_stall = w_is_m;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 6'd0) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_valid = 1'b1;
        if (bus.ex_advance_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (bus.flush_i) begin
      w_state_next = S_IDLE;
      w_stall      = 1'b0;
      w_valid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 6'd0;
      r_div      <= 1'b0;
      r_w        <= 1'b0;
      r_rem      <= 1'b0;
      r_hi       <= 1'b0;
      r_special  <= 1'b0;
      r_neg      <= 1'b0;
      r_neg_r    <= 1'b0;
      r_spec_res <= 64'd0;
      r_x        <= 64'd0;
      r_y        <= 64'd0;
      r_rrem     <= 64'd0;
      r_mcand    <= 128'd0;
      r_acc      <= 128'd0;
      r_result   <= 64'd0;
    end else if (w_start) begin
      r_cnt      <= w_cnt_init;
      r_div      <= w_is_div;
      r_w        <= w_is_w;
      r_rem      <= w_is_rem;
      r_hi       <= (bus.funct3_i[1:0] != 2'b00);
      r_special  <= w_special;
      r_spec_res <= w_spec_res;
      r_neg      <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_acc      <= 128'd0;
      r_rrem     <= 64'd0;
      r_mcand    <= {64'd0, w_a_mag};
      r_y        <= w_b_mag;
      // W divides park the 32-bit dividend at the top so 32 shifts consume it.
      r_x        <= w_is_div ? (w_is_w ? {w_a_mag[31:0], 32'd0} : w_a_mag) : w_b_mag;
    end else if ((r_state == S_BUSY) && !bus.flush_i) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_rrem  <= w_rem_next;
      r_x     <= r_div ? w_q_next : (r_x >> 1);
      if (r_cnt == 6'd0) r_result <= w_final;
      else               r_cnt    <= r_cnt - 6'd1;
    end
  end

  assign bus.stall_req_o    = w_stall;
  assign bus.result_valid_o = w_valid;
  assign bus.result_o       = r_result;
  assign bus.dbg_state_o    = r_state;
endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized bench for ex_muldiv: per-cycle stall/valid/result checks against an arithmetic model.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  ex_muldiv_if bus();

  ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_RW = 7'b0111011;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_res_zero = 1'b0;
  logic        tb_done = 1'b0;
  logic [6:0]  op_tab[13];
  logic [2:0]  f3_tab[13];

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model_result(input logic [6:0] op, input logic [2:0] f3,
                                               input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, ua, ub, p;
    logic signed [63:0] sa, sb, sq;
    logic signed [31:0] sa32, sb32, sq32;
    logic [31:0] ua32, ub32, t;
    ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b};
    ua = {64'd0, a};       ub = {64'd0, b};
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    ua32 = a[31:0]; ub32 = b[31:0];
    if (op == OP_R) begin
      case (f3)
        3'd0: begin p = ua * ub; return p[63:0]; end
        3'd1: begin p = ea * eb; return p[127:64]; end
        3'd2: begin p = ea * ub; return p[127:64]; end
        3'd3: begin p = ua * ub; return p[127:64]; end
        3'd4: begin
          if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
          if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
          sq = sa / sb; return sq;
        end
        3'd5: return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
        3'd6: begin
          if (b == 64'd0) return a;
          if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0;
          sq = sa % sb; return sq;
        end
        default: return (b == 64'd0) ? a : a % b;
      endcase
    end
    case (f3)
      3'd0: begin t = ua32 * ub32; return sx32(t); end
      3'd4: begin
        if (ub32 == 32'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) return sx32(ua32);
        sq32 = sa32 / sb32; return sx32(sq32);
      end
      3'd5: begin
        if (ub32 == 32'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
        t = ua32 / ub32; return sx32(t);
      end
      3'd6: begin
        if (ub32 == 32'd0) return sx32(ua32);
        if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) return 64'd0;
        sq32 = sa32 % sb32; return sx32(sq32);
      end
      default: begin
        if (ub32 == 32'd0) return sx32(ua32);
        t = ua32 % ub32; return sx32(t);
      end
    endcase
  endfunction

  // Number of BUSY cycles; valid rises one cycle after the last of them.
  function automatic int model_lat(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b);
    logic w;
    w = (op == OP_RW);
    if (f3[2]) begin
      if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
      if (!f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
        return 1;
      return w ? 32 : 64;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return w ? 32 : 64;
`endif
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {$urandom, $urandom};
      4: begin
        v = 64'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) v = 64'd0 - v;
      end
      default: v = {$urandom, 32'h8000_0000};
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic drive_nop();
    bus.opcode_i     = 7'b0010011;
    bus.funct3_i     = 3'd0;
    bus.funct7_i     = 7'd0;
    bus.rs1_data_i   = 64'd0;
    bus.rs2_data_i   = 64'd0;
    bus.flush_i      = 1'b0;
    bus.ex_advance_i = 1'b0;
  endtask

  // Holds one instruction in ID/EX from cycle T until it advances, or until a flush/reset aborts it.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input int hold, input int flush_k, input int rst_k,
                        input logic use_lit, input logic [63:0] lit);
    int n, abort_k, k;
    logic stop;
    n = model_lat(op, f3, a, b);
    abort_k = (flush_k >= 0) ? flush_k : rst_k;
    if (abort_k < 0 || abort_k > n)
      exp_q.push_back(use_lit ? lit : model_result(op, f3, a, b));
    k = 0;
    stop = 1'b0;
    while (!stop) begin
      @(posedge clk); #1;
      bus.opcode_i = op; bus.funct3_i = f3; bus.funct7_i = 7'b0000001;
      bus.rs1_data_i = a; bus.rs2_data_i = b;
      bus.flush_i = 1'b0; bus.ex_advance_i = 1'b0; rst = 1'b0;
      exp_res_zero = 1'b0;
      exp_stall = (k <= n);
      exp_valid = (k > n);
      if (k == flush_k) begin
        bus.flush_i = 1'b1; exp_stall = 1'b0; exp_valid = 1'b0; stop = 1'b1;
      end else if (k == rst_k) begin
        rst = 1'b1; stop = 1'b1;
      end else if (k == n + 1 + hold) begin
        bus.ex_advance_i = 1'b1; stop = 1'b1;
      end
      k++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
    exp_stall = 1'b0; exp_valid = 1'b0; exp_res_zero = (rst_k >= 0 && flush_k < 0);
  endtask

  task automatic run_nonm(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.opcode_i = op; bus.funct3_i = f3; bus.funct7_i = f7;
      bus.rs1_data_i = 64'd77; bus.rs2_data_i = 64'd5;
      exp_stall = 1'b0; exp_valid = 1'b0; exp_res_zero = 1'b0;
    end
    @(posedge clk); #1;
    drive_nop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : compare
    logic prev_exp_valid;
    logic [63:0] held;
    prev_exp_valid = 1'b0;
    held = 64'd0;
    chk("pin_div",    model_result(OP_R, 3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("pin_rem",    model_result(OP_R, 3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_divu0",  model_result(OP_R, 3'd5, 64'h1234, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_remu0",  model_result(OP_R, 3'd7, 64'h1234, 64'd0), 64'h1234);
    chk("pin_ovf",    model_result(OP_R, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF), 64'h8000_0000_0000_0000);
    chk("pin_mulw",   model_result(OP_RW, 3'd0, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_mulhu",  model_result(OP_R, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_mulhsu", model_result(OP_R, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_divw",   model_result(OP_RW, 3'd4, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_lat_div", 64'(model_lat(OP_R, 3'd4, 64'd20, 64'd3)), 64'd64);
    while (!tb_done) begin
      @(negedge clk);
      if (chk_en) begin
        chk("stall_req", {63'd0, bus.stall_req_o}, {63'd0, exp_stall});
        chk("result_valid", {63'd0, bus.result_valid_o}, {63'd0, exp_valid});
        if (exp_valid && !prev_exp_valid) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard got=empty exp=entry at %0t", $time);
          end else begin
            held = exp_q.pop_front();
          end
        end
        if (exp_valid) chk("result", bus.result_o, held);
        if (exp_res_zero) chk("reset_result", bus.result_o, 64'd0);
        prev_exp_valid = exp_valid;
      end
    end
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : driver
    int idx, n, hold, fk, rk, sel;
    logic [63:0] a, b;
    op_tab  = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_RW, OP_RW, OP_RW, OP_RW, OP_RW};
    f3_tab  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
    rst = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    chk_en = 1'b1; exp_res_zero = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(OP_R, 3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 0, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_R, 3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 3, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_R, 3'd5, 64'h1234, 64'd0, 1, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(OP_R, 3'd7, 64'h1234, 64'd0, 0, -1, -1, 1'b1, 64'h1234);
    run_op(OP_R, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, -1, 1'b1, 64'h8000_0000_0000_0000);
    run_op(OP_R, 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, -1, 1'b1, 64'd0);
    run_op(OP_RW, 3'd0, 64'h7FFF_FFFF, 64'd2, 2, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_R, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(OP_R, 3'd4, 64'd1000, 64'd7, 0, 10, -1, 1'b0, 64'd0);
    run_op(OP_R, 3'd5, 64'd1000, 64'd7, 0, -1, 5, 1'b0, 64'd0);
    run_nonm(OP_R, 3'd4, 7'd0);
    run_nonm(OP_RW, 3'd1, 7'b0000001);

    for (int i = 0; i < 45; i++) begin
      idx  = int'($urandom_range(0, 12));
      a    = rand_operand();
      b    = rand_operand();
      n    = model_lat(op_tab[idx], f3_tab[idx], a, b);
      hold = int'($urandom_range(0, 3));
      fk   = -1;
      rk   = -1;
      sel  = int'($urandom_range(0, 9));
      if (sel == 0)      fk = int'($urandom_range(0, n));
      else if (sel == 1) rk = int'($urandom_range(1, n + 1));
      run_op(op_tab[idx], f3_tab[idx], a, b, hold, fk, rk, 1'b0, 64'd0);
      if (sel == 2) run_nonm(OP_R, 3'd0, 7'b0100000);
    end

    @(posedge clk); #1;
    drive_nop();
    exp_stall = 1'b0; exp_valid = 1'b0; exp_res_zero = 1'b0;
    @(posedge clk); #1;
    tb_done = 1'b1;
  end
endmodule
